// File: rtl/alu_sched_if.sv
// Request/response bundle between two requesters and the alu_sched scheduler.
interface alu_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [31:0] req_b0;
    logic [31:0] req_b1;
    logic [2:0]  req_op0;
    logic [2:0]  req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_sched.sv
// Two-port scheduler sharing one combinational 32-bit ALU; one op in flight at a time.
// Optional macro ALU_SCHED_RR_EN selects round-robin arbitration instead of fixed priority.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] c
);
    logic signed [31:0] a_s;
    assign a_s = a;

    always_comb begin
        c = '0;
        case (op)
            3'b000: c = a + b;
            3'b001: c = a - b;
            3'b010: c = a & b;
            3'b011: c = a | b;
            // Shift amount is the whole of B, so 32 or more flushes the operand.
            3'b100: c = (b >= 32'd32) ? 32'd0 : (a >> b[4:0]);
            3'b101: c = (b >= 32'd32) ? {32{a[31]}} : 32'(a_s >>> b[4:0]);
            default: c = '0;
        endcase
    end
endmodule

module alu_sched (
    input  logic        clk,
    input  logic        reset_n,
    alu_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        win;
    logic        accept;
    logic        gnt_q;
    logic [31:0] a_q, b_q, res_q, alu_c;
    logic [2:0]  op_q;
    logic        err_q;
    logic [1:0]  rsp_valid_q;
    logic [1:0]  req_ready;
`ifdef ALU_SCHED_RR_EN
    logic        rr_q;
`endif

    // Arbitration winner; a lone requester always wins.
    always_comb begin
`ifdef ALU_SCHED_RR_EN
        if (bus.req_valid == 2'b11) win = rr_q;
        else                        win = ~bus.req_valid[0];
`else
        win = ~bus.req_valid[0];
`endif
    end

    assign accept = (state_q == IDLE) && bus.req_valid[win];

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: if (accept) begin
                req_ready[win] = 1'b1;
                state_d        = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: if (bus.rsp_ready[gnt_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    alu u_alu (.a(a_q), .b(b_q), .op(op_q), .c(alu_c));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            gnt_q       <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
`ifdef ALU_SCHED_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_q   <= win ? bus.req_a1  : bus.req_a0;
                b_q   <= win ? bus.req_b1  : bus.req_b0;
                op_q  <= win ? bus.req_op1 : bus.req_op0;
                gnt_q <= win;
`ifdef ALU_SCHED_RR_EN
                rr_q  <= ~win;
`endif
            end
            if (state_q == EXEC) begin
                res_q       <= alu_c;
                err_q       <= op_q[2] & op_q[1];
                rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
            end
            if (state_q == RESP && bus.rsp_ready[gnt_q]) rsp_valid_q <= 2'b00;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = res_q;
    assign bus.rsp_err   = err_q & (|rsp_valid_q);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_sched.sv
// Table-driven bench for alu_sched plus directed contention, backpressure and reset sequences.
module tb_alu_sched;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    alu_sched_if bus ();
    alu_sched dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        logic [1:0] oh;
        oh = (v.port == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        bus.req_valid = oh;
        bus.rsp_ready = oh;
        if (v.port == 0) begin
            bus.req_a0 = v.a; bus.req_b0 = v.b; bus.req_op0 = v.op;
        end else begin
            bus.req_a1 = v.a; bus.req_b1 = v.b; bus.req_op1 = v.op;
        end
        for (n = 0; n < 10; n++) begin
            #1;
            if (bus.req_ready != 2'b00) break;
            @(negedge clk);
        end
        check($sformatf("v%0d_req_ready", idx), {30'd0, bus.req_ready}, {30'd0, oh});
        if (n >= 10) begin
            bus.req_valid = 2'b00;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble requester inputs: the latched copy must be used.
        bus.req_valid = 2'b00;
        bus.req_a0 = ~bus.req_a0; bus.req_b0 = bus.req_b0 + 32'd3; bus.req_op0 = ~bus.req_op0;
        bus.req_a1 = ~bus.req_a1; bus.req_b1 = bus.req_b1 + 32'd3; bus.req_op1 = ~bus.req_op1;
        @(negedge clk);
        check($sformatf("v%0d_exec_rsp_valid", idx), {30'd0, bus.rsp_valid}, 32'd0);
        check($sformatf("v%0d_exec_busy", idx), {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check($sformatf("v%0d_rsp_valid", idx), {30'd0, bus.rsp_valid}, {30'd0, oh});
        check($sformatf("v%0d_rsp_data", idx), bus.rsp_data, v.exp_data);
        check($sformatf("v%0d_rsp_err", idx), {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", idx), {31'd0, bus.busy}, 32'd0);
        check($sformatf("v%0d_idle_rsp_valid", idx), {30'd0, bus.rsp_valid}, 32'd0);
        bus.rsp_ready = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int got;
        logic [1:0] grants[4];
        logic [1:0] exp_g[4];
        logic [31:0] held;
        logic stable;

        vecs[0] = '{0, 32'd1,          32'd2,  3'b000, 32'd3,          1'b0};
        vecs[1] = '{1, 32'h80000000,   32'd4,  3'b101, 32'hF8000000,   1'b0};
        vecs[2] = '{1, 32'h80000000,   32'd4,  3'b100, 32'h08000000,   1'b0};
        vecs[3] = '{1, 32'd0,          32'd1,  3'b001, 32'hFFFFFFFF,   1'b0};
        vecs[4] = '{1, 32'h80000000,   32'd40, 3'b101, 32'hFFFFFFFF,   1'b0};
        vecs[5] = '{0, 32'h80000000,   32'd40, 3'b100, 32'd0,          1'b0};
        vecs[6] = '{0, 32'd5,          32'd6,  3'b111, 32'd0,          1'b1};
        vecs[7] = '{1, 32'hFFFFFFFF,   32'd2,  3'b000, 32'd1,          1'b0};
        vecs[8] = '{0, 32'd9,          32'd3,  3'b110, 32'd0,          1'b1};
        vecs[9] = '{0, 32'h7FFFFFFF,   32'd31, 3'b101, 32'd0,          1'b0};

        reset_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
        bus.req_op0 = '0; bus.req_op1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Contention: both ports request continuously for four ops.
        do_reset();
        bus.req_a0 = 32'd10; bus.req_b0 = 32'd1; bus.req_op0 = 3'b000;
        bus.req_a1 = 32'd20; bus.req_b1 = 32'd2; bus.req_op1 = 3'b000;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                grants[got] = bus.req_ready;
                got++;
            end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        check("cont_grant_count", got, 32'd4);
`ifdef ALU_SCHED_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int k = 0; k < got; k++)
            check($sformatf("cont_grant%0d", k), {30'd0, grants[k]}, {30'd0, exp_g[k]});
        repeat (4) @(negedge clk);
        bus.rsp_ready = 2'b00;

        // Backpressure on port 0; port 1 rsp_ready must be ignored.
        bus.req_a0 = 32'd100; bus.req_b0 = 32'd23; bus.req_op0 = 3'b001;
        bus.req_valid = 2'b01;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.req_ready[0]) begin got = 1; break; end
            @(negedge clk);
        end
        check("bp_accept", got, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b10;
        bus.req_a1 = 32'd1; bus.req_b1 = 32'd1; bus.req_op1 = 3'b000;
        bus.rsp_ready = 2'b10;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid == 2'b01) begin got = 1; break; end
        end
        check("bp_rsp_seen", got, 32'd1);
        held = bus.rsp_data;
        check("bp_rsp_data", held, 32'd77);
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== held ||
                bus.req_ready !== 2'b00 || bus.busy !== 1'b1) stable = 1'b0;
        end
        check("bp_hold_stable", {31'd0, stable}, 32'd1);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        check("bp_release_busy", {31'd0, bus.busy}, 32'd0);
        check("bp_release_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        bus.rsp_ready = 2'b00;

        // Reset during EXEC drops the op.
        bus.req_a0 = 32'd7; bus.req_b0 = 32'd8; bus.req_op0 = 3'b000;
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b01;
        #1;
        check("rstop_accept", {30'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("rstop_exec_busy", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rstop_busy", {31'd0, bus.busy}, 32'd0);
        check("rstop_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        reset_n = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) stable = 1'b0;
        end
        check("rstop_no_response", {31'd0, stable}, 32'd1);
        bus.rsp_ready = 2'b00;
        run_vec(vecs[0], 10);
        run_vec(vecs[1], 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
